// File: rtl/floo_clint_pkg.sv
// Shared address map, handshake state and response types for the CLINT register block.
package floo_clint_pkg;

  localparam logic [15:0] MsipBase     = 16'h0000;
  localparam logic [15:0] MtimecmpBase = 16'h4000;
  localparam logic [15:0] MtimeLo      = 16'hBFF8;
  localparam logic [15:0] MtimeHi      = 16'hBFFC;

  typedef enum logic {Idle, Resp} clint_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } clint_rsp_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/floo_clint_timer.sv
// Machine timer: prescaler, 64-bit mtime, per-hart mtimecmp and registered mtip compare.
// Only instantiated when FLOO_CLINT_MTIMER_EN is defined.
module floo_clint_timer
  import floo_clint_pkg::*;
#(
  parameter int unsigned NumCores    = 9,
  parameter int unsigned PrescaleDiv = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [15:0]         off_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          wstrb_i,
  output logic                hit_o,
  output logic [31:0]         rdata_o,
  output logic [NumCores-1:0] mtip_o
);

  logic [15:0]         presc_q, presc_d;
  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         cmp_q [NumCores];
  logic [63:0]         cmp_d [NumCores];
  logic [NumCores-1:0] mtip_q, mtip_d;

  logic [15:0] cmp_off;
  logic [12:0] cmp_idx;
  logic        cmp_hit, lo_hit, hi_hit, tick;
  logic        unused_off;

  assign cmp_off    = off_i - MtimecmpBase;
  assign cmp_idx    = cmp_off[15:3];
  assign cmp_hit    = (off_i >= MtimecmpBase) && (cmp_idx < 13'(NumCores));
  assign lo_hit     = (off_i == MtimeLo);
  assign hi_hit     = (off_i == MtimeHi);
  assign hit_o      = cmp_hit | lo_hit | hi_hit;
  assign tick       = (presc_q == 16'(PrescaleDiv - 1));
  assign unused_off = ^cmp_off[1:0];

  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    // A software write owns its half and suppresses the increment for the other half.
    if (we_i && lo_hit) begin
      mtime_d = {mtime_q[63:32], apply_wstrb(mtime_q[31:0], wdata_i, wstrb_i)};
      presc_d = 16'd0;
    end else if (we_i && hi_hit) begin
      mtime_d = {apply_wstrb(mtime_q[63:32], wdata_i, wstrb_i), mtime_q[31:0]};
      presc_d = 16'd0;
    end
    cmp_d   = cmp_q;
    rdata_o = '0;
    if (lo_hit) rdata_o = mtime_q[31:0];
    if (hi_hit) rdata_o = mtime_q[63:32];
    for (int i = 0; i < NumCores; i++) begin
      mtip_d[i] = (mtime_q >= cmp_q[i]);
      if (cmp_hit && (cmp_idx == 13'(i))) begin
        rdata_o = off_i[2] ? cmp_q[i][63:32] : cmp_q[i][31:0];
        if (we_i) begin
          if (off_i[2]) cmp_d[i][63:32] = apply_wstrb(cmp_q[i][63:32], wdata_i, wstrb_i);
          else          cmp_d[i][31:0]  = apply_wstrb(cmp_q[i][31:0], wdata_i, wstrb_i);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      mtime_q <= '0;
      mtip_q  <= '0;
      for (int i = 0; i < NumCores; i++) cmp_q[i] <= '1;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      mtip_q  <= mtip_d;
      cmp_q   <= cmp_d;
    end
  end

  assign mtip_o = mtip_q;

endmodule

// File: rtl/floo_clint_ctrl.sv
// Core-local interruptor: msip registers plus optional machine timer behind a one-deep
// request/response register port. Timer enabled by defining FLOO_CLINT_MTIMER_EN.
module floo_clint_ctrl
  import floo_clint_pkg::*;
#(
  parameter int unsigned NumCores    = 9,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned PrescaleDiv = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [NumCores-1:0]  msip_o,
  output logic [NumCores-1:0]  mtip_o
);

  clint_state_e        state_q, state_d;
  clint_rsp_t          rsp_q, rsp_d;
  logic [NumCores-1:0] msip_q, msip_d;

  logic [15:0] off;
  logic [13:0] msip_idx;
  logic        accept, aligned, msip_hit, hit;
  logic [31:0] msip_rdata, rdata;
  logic        tmr_hit;
  logic [31:0] tmr_rdata;
  logic        unused_addr;

  assign off         = req_addr_i[15:0];
  assign msip_idx    = off[15:2];
  assign aligned     = (off[1:0] == 2'b00);
  assign accept      = req_valid_i & req_ready_o;
  assign msip_hit    = (off < MsipBase + 16'(4 * NumCores));
  assign hit         = aligned & (msip_hit | tmr_hit);
  assign unused_addr = ^req_addr_i[AddrWidth-1:16];

`ifdef FLOO_CLINT_MTIMER_EN
  floo_clint_timer #(
    .NumCores    (NumCores),
    .PrescaleDiv (PrescaleDiv)
  ) i_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (accept & req_write_i & aligned),
    .off_i   (off),
    .wdata_i (req_wdata_i),
    .wstrb_i (req_wstrb_i),
    .hit_o   (tmr_hit),
    .rdata_o (tmr_rdata),
    .mtip_o  (mtip_o)
  );
`else
  assign tmr_hit   = 1'b0;
  assign tmr_rdata = '0;
  assign mtip_o    = '0;
`endif

  always_comb begin
    msip_rdata = '0;
    for (int i = 0; i < NumCores; i++) begin
      if (msip_hit && (msip_idx == 14'(i))) msip_rdata = {31'd0, msip_q[i]};
    end
    rdata = msip_hit ? msip_rdata : tmr_rdata;
  end

  always_comb begin
    state_d     = state_q;
    rsp_d       = rsp_q;
    msip_d      = msip_q;
    req_ready_o = (state_q == Idle);
    rsp_valid_o = (state_q == Resp);
    unique case (state_q)
      Idle: begin
        if (accept) begin
          rsp_d.error = ~hit;
          rsp_d.rdata = (hit && !req_write_i) ? rdata : 32'd0;
          if (hit && req_write_i && msip_hit && req_wstrb_i[0]) begin
            for (int i = 0; i < NumCores; i++) begin
              if (msip_idx == 14'(i)) msip_d[i] = req_wdata_i[0];
            end
          end
          state_d = Resp;
        end
      end
      Resp: begin
        if (rsp_ready_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= Idle;
      rsp_q   <= '0;
      msip_q  <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      msip_q  <= msip_d;
    end
  end

  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_error_o = rsp_q.error;
  assign msip_o      = msip_q;

endmodule

// File: tb/tb_floo_clint_ctrl.sv
// Directed bench for floo_clint_ctrl; timer checks run only when FLOO_CLINT_MTIMER_EN is defined.
module tb_floo_clint_ctrl;
  import floo_clint_pkg::*;

  localparam int unsigned NC = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic          req_write = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic [NC-1:0] msip;
  logic [NC-1:0] mtip;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;
  logic        err;

  always #5 clk = ~clk;

  floo_clint_ctrl #(
    .NumCores    (NC),
    .AddrWidth   (32),
    .PrescaleDiv (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_error_o (rsp_error),
    .msip_o      (msip),
    .mtip_o      (mtip)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; response is checked to appear exactly one cycle after acceptance.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic error);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rsp_latency", 64'(rsp_valid), 64'd1);
    rdata = rsp_rdata;
    error = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    // Reset state while rst is held
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_error", 64'(rsp_error), 64'd0);
    check("rst_msip", 64'(msip), 64'd0);
    check("rst_mtip", 64'(mtip), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // msip set/read
    access(1'b1, 32'h0000_0008, 32'h1, 4'hF, rd, err);
    check("msip2_wr_err", 64'(err), 64'd0);
    check("msip2_wr_rdata", 64'(rd), 64'd0);
    check("msip2_out", 64'(msip), 64'h004);
    access(1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, err);
    check("msip2_rd", 64'(rd), 64'h1);
    check("msip2_rd_err", 64'(err), 64'd0);

    // Byte strobe without byte 0 leaves msip untouched, then last hart set
    access(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hE, rd, err);
    check("msip8_nostrb", 64'(msip), 64'h004);
    access(1'b1, 32'h0000_0020, 32'h0000_0003, 4'h1, rd, err);
    check("msip8_set", 64'(msip), 64'h104);
    access(1'b0, 32'h0000_0020, 32'h0, 4'h0, rd, err);
    check("msip8_rd", 64'(rd), 64'h1);

    // Out-of-range hart, misaligned address, upper address bits ignored
    access(1'b0, 32'h0000_0024, 32'h0, 4'h0, rd, err);
    check("msip9_rd_err", 64'(err), 64'd1);
    check("msip9_rd_data", 64'(rd), 64'd0);
    access(1'b1, 32'h0000_0024, 32'h1, 4'hF, rd, err);
    check("msip9_wr_err", 64'(err), 64'd1);
    check("msip9_wr_nochange", 64'(msip), 64'h104);
    access(1'b0, 32'h0000_0002, 32'h0, 4'h0, rd, err);
    check("misalign_err", 64'(err), 64'd1);
    check("misalign_data", 64'(rd), 64'd0);
    access(1'b1, 32'h0000_000A, 32'h0, 4'hF, rd, err);
    check("misalign_wr_err", 64'(err), 64'd1);
    check("misalign_wr_nochange", 64'(msip), 64'h104);
    access(1'b0, 32'h1234_0008, 32'h0, 4'h0, rd, err);
    check("upper_addr_rd", 64'(rd), 64'h1);
    access(1'b0, 32'h0000_1000, 32'h0, 4'h0, rd, err);
    check("unmapped_err", 64'(err), 64'd1);

`ifdef FLOO_CLINT_MTIMER_EN
    access(1'b0, 32'h0000_4000, 32'h0, 4'h0, rd, err);
    check("cmp0_reset_lo", 64'(rd), 64'hFFFF_FFFF);
    check("cmp0_reset_err", 64'(err), 64'd0);
    access(1'b0, 32'h0000_4048, 32'h0, 4'h0, rd, err);
    check("cmp9_err", 64'(err), 64'd1);
    access(1'b1, 32'h0000_4000, 32'd100, 4'hF, rd, err);
    access(1'b1, 32'h0000_4004, 32'd0, 4'hF, rd, err);
    access(1'b1, 32'h0000_BFF8, 32'd0, 4'hF, rd, err);
    check("mtip0_low_early", 64'(mtip[0]), 64'd0);
    begin
      int n = 0;
      while (!mtip[0] && n < 1000) begin
        @(posedge clk); #1;
        n++;
      end
      check("mtip0_rise", 64'(mtip[0]), 64'd1);
      check("mtip0_rise_time", 64'(n > 350 && n < 420), 64'd1);
    end
    check("mtip1_low", 64'(mtip[1]), 64'd0);
    access(1'b0, 32'h0000_BFF8, 32'h0, 4'h0, rd, err);
    check("mtime_ge_cmp", 64'(rd >= 32'd100), 64'd1);
    access(1'b1, 32'h0000_4004, 32'd1, 4'hF, rd, err);
    check("mtip0_fall", 64'(mtip[0]), 64'd0);
    access(1'b1, 32'h0000_BFF8, 32'h1234_5678, 4'hF, rd, err);
    access(1'b0, 32'h0000_BFF8, 32'h0, 4'h0, rd, err);
    check("mtime_wr_exact", 64'(rd), 64'h1234_5678);
    access(1'b1, 32'h0000_BFFC, 32'hFFFF_FFFF, 4'hF, rd, err);
    access(1'b1, 32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, rd, err);
    repeat (10) @(posedge clk);
    access(1'b0, 32'h0000_BFFC, 32'h0, 4'h0, rd, err);
    check("mtime_wrap_hi", 64'(rd), 64'd0);
    access(1'b0, 32'h0000_BFF8, 32'h0, 4'h0, rd, err);
    check("mtime_wrap_lo_small", 64'(rd < 32'd16), 64'd1);
    check("mtip0_after_wrap", 64'(mtip[0]), 64'd0);
`else
    access(1'b0, 32'h0000_4000, 32'h0, 4'h0, rd, err);
    check("notimer_cmp_err", 64'(err), 64'd1);
    check("notimer_cmp_data", 64'(rd), 64'd0);
    access(1'b0, 32'h0000_BFF8, 32'h0, 4'h0, rd, err);
    check("notimer_mtime_err", 64'(err), 64'd1);
    check("notimer_mtip", 64'(mtip), 64'd0);
`endif

    // Back-to-back request held off while the response is stalled
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0008;
    @(posedge clk); #1;
    check("b2b_first_rsp", 64'(rsp_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("b2b_ready_low", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    check("b2b_rsp_stable", 64'(rsp_rdata), 64'h1);
    check("b2b_rsp_still_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("b2b_ready_back", 64'(req_ready), 64'd1);
    check("b2b_rsp_dropped", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_second_rsp", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    check("b2b_second_done", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b0;

    // Asynchronous reset while a response is pending
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0020;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("arst_in_resp", 64'(rsp_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd1);
    check("arst_msip", 64'(msip), 64'd0);
    check("arst_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, err);
    check("post_rst_msip2", 64'(rd), 64'd0);
    check("post_rst_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
